// File: rtl/register_file_pkg.sv
// Shared definitions for the architectural register file: boolean constants,
// register-file geometry, the default truncated ROB index width and the
// operand record produced by each source-operand resolver.
package register_file_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_AW     = 5;
    localparam int ROB_WD_DEF = 4;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] reg_idx_t;

    localparam reg_idx_t X0 = '0;

    // Result of resolving one source operand against the register file.
    typedef struct packed {
        logic  ready;
        word_t val;
        word_t tag;
    } operand_t;

    // x0 is hard-wired to zero, so nothing may ever write or rename it.
    function automatic logic is_writable(input reg_idx_t rd);
        return (rd != X0);
    endfunction

endpackage

// File: rtl/register_file_operand_resolve.sv
// Combinational resolution of one source operand. Walks the priority chain:
// x0, committed value, same-cycle commit bypass, ROB forward, otherwise stall
// with the producing ROB id exposed as the tag.
module operand_resolve
    import register_file_pkg::*;
#(
    parameter int ROB_WD = ROB_WD_DEF
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              busy,
    input  logic [XLEN-1:0]   reg_val,
    input  logic [XLEN-1:0]   reg_tag,
    input  logic              cmt_flag,
    input  logic [REG_AW-1:0] cmt_rd,
    input  logic [XLEN-1:0]   cmt_rob_id,
    input  logic [XLEN-1:0]   cmt_val,
    input  logic              rob_ready,
    input  logic [XLEN-1:0]   rob_val,
    output logic              ready,
    output logic [XLEN-1:0]   val,
    output logic [XLEN-1:0]   tag,
    output logic [ROB_WD-1:0] rob_id
);

    operand_t result;

    // Pick the freshest available value for this source, or report the tag to wait on.
    always_comb begin
        result.ready = TRUE;
        result.val   = '0;
        result.tag   = '0;
        if (rs == X0) begin
            result.ready = TRUE;
            result.val   = '0;
        end else if (!busy) begin
            result.ready = TRUE;
            result.val   = reg_val;
        end else if (cmt_flag && (cmt_rd == rs) && (cmt_rob_id == reg_tag)) begin
            result.ready = TRUE;
            result.val   = cmt_val;
        end else if (rob_ready) begin
            result.ready = TRUE;
            result.val   = rob_val;
        end else begin
            result.ready = FALSE;
            result.tag   = reg_tag;
        end
    end

    // The ROB lookup index is the low bits of the stored tag, busy or not.
    always_comb begin
        ready  = result.ready;
        val    = result.val;
        tag    = result.tag;
        rob_id = reg_tag[ROB_WD-1:0];
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags. Decode marks a
// destination busy with its ROB id; the ROB commit port writes values and
// clears the busy bit only when the committing id is still the newest
// producer. Two source operands are resolved combinationally each cycle.
module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_WD = ROB_WD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,

    input  logic              id_rn_flag,
    input  logic [REG_AW-1:0] id_rn_rd,
    input  logic [XLEN-1:0]   id_rn_rob_id,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,

    output logic              rs1_ready,
    output logic [XLEN-1:0]   rs1_val,
    output logic [XLEN-1:0]   rs1_tag,
    output logic              rs2_ready,
    output logic [XLEN-1:0]   rs2_val,
    output logic [XLEN-1:0]   rs2_tag,

    output logic [ROB_WD-1:0] rob_q1_id,
    output logic [ROB_WD-1:0] rob_q2_id,
    input  logic              rob_q1_ready,
    input  logic [XLEN-1:0]   rob_q1_val,
    input  logic              rob_q2_ready,
    input  logic [XLEN-1:0]   rob_q2_val,

    input  logic              cmt_flag,
    input  logic [REG_AW-1:0] cmt_rd,
    input  logic [XLEN-1:0]   cmt_rob_id,
    input  logic [XLEN-1:0]   cmt_val
);

    word_t                value_q [REG_COUNT];
    word_t                tag_q   [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;

    logic cmt_write;
    logic cmt_matches;
    logic rn_write;

    // Decode which of this cycle's update requests actually take effect.
    always_comb begin
        cmt_write   = cmt_flag && is_writable(cmt_rd);
        cmt_matches = busy_q[cmt_rd] && (tag_q[cmt_rd] == cmt_rob_id);
        rn_write    = id_rn_flag && is_writable(id_rn_rd);
    end

    // Committed values: any commit to a real register lands, even during a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
            end
        end else if (rdy && cmt_write) begin
            value_q[cmt_rd] <= cmt_val;
        end
    end

    // Rename state: flush wipes all busy bits, rename overrides a same-cycle commit clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                tag_q[i] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                busy_q <= '0;
            end else begin
                if (cmt_write && cmt_matches) begin
                    busy_q[cmt_rd] <= FALSE;
                end
                if (rn_write) begin
                    busy_q[id_rn_rd] <= TRUE;
                    tag_q[id_rn_rd]  <= id_rn_rob_id;
                end
            end
        end
    end

    operand_resolve #(
        .ROB_WD (ROB_WD)
    ) u_resolve_rs1 (
        .rs         (id_rs1),
        .busy       (busy_q[id_rs1]),
        .reg_val    (value_q[id_rs1]),
        .reg_tag    (tag_q[id_rs1]),
        .cmt_flag   (cmt_flag),
        .cmt_rd     (cmt_rd),
        .cmt_rob_id (cmt_rob_id),
        .cmt_val    (cmt_val),
        .rob_ready  (rob_q1_ready),
        .rob_val    (rob_q1_val),
        .ready      (rs1_ready),
        .val        (rs1_val),
        .tag        (rs1_tag),
        .rob_id     (rob_q1_id)
    );

    operand_resolve #(
        .ROB_WD (ROB_WD)
    ) u_resolve_rs2 (
        .rs         (id_rs2),
        .busy       (busy_q[id_rs2]),
        .reg_val    (value_q[id_rs2]),
        .reg_tag    (tag_q[id_rs2]),
        .cmt_flag   (cmt_flag),
        .cmt_rd     (cmt_rd),
        .cmt_rob_id (cmt_rob_id),
        .cmt_val    (cmt_val),
        .rob_ready  (rob_q2_ready),
        .rob_val    (rob_q2_val),
        .ready      (rs2_ready),
        .val        (rs2_val),
        .tag        (rs2_tag),
        .rob_id     (rob_q2_id)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by a
// randomized phase, all checked against a behavioural model of the register
// file kept as plain arrays.
module tb_register_file;

    localparam int ROB_WD = 4;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              flush;
    logic              id_rn_flag;
    logic [4:0]        id_rn_rd;
    logic [31:0]       id_rn_rob_id;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              rs1_ready;
    logic [31:0]       rs1_val;
    logic [31:0]       rs1_tag;
    logic              rs2_ready;
    logic [31:0]       rs2_val;
    logic [31:0]       rs2_tag;
    logic [ROB_WD-1:0] rob_q1_id;
    logic [ROB_WD-1:0] rob_q2_id;
    logic              rob_q1_ready;
    logic [31:0]       rob_q1_val;
    logic              rob_q2_ready;
    logic [31:0]       rob_q2_val;
    logic              cmt_flag;
    logic [4:0]        cmt_rd;
    logic [31:0]       cmt_rob_id;
    logic [31:0]       cmt_val;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] m_val  [32];
    logic [31:0] m_tag  [32];
    logic        m_busy [32];

    register_file #(.ROB_WD(ROB_WD)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .flush        (flush),
        .id_rn_flag   (id_rn_flag),
        .id_rn_rd     (id_rn_rd),
        .id_rn_rob_id (id_rn_rob_id),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .rs1_ready    (rs1_ready),
        .rs1_val      (rs1_val),
        .rs1_tag      (rs1_tag),
        .rs2_ready    (rs2_ready),
        .rs2_val      (rs2_val),
        .rs2_tag      (rs2_tag),
        .rob_q1_id    (rob_q1_id),
        .rob_q2_id    (rob_q2_id),
        .rob_q1_ready (rob_q1_ready),
        .rob_q1_val   (rob_q1_val),
        .rob_q2_ready (rob_q2_ready),
        .rob_q2_val   (rob_q2_val),
        .cmt_flag     (cmt_flag),
        .cmt_rd       (cmt_rd),
        .cmt_rob_id   (cmt_rob_id),
        .cmt_val      (cmt_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_tag[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge, straight from the update rules.
    task automatic modelUpdate();
        if (rst && rdy) begin
            if (cmt_flag && cmt_rd != 0) begin
                m_val[cmt_rd] = cmt_val;
                if (!flush && m_busy[cmt_rd] && m_tag[cmt_rd] == cmt_rob_id)
                    m_busy[cmt_rd] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (id_rn_flag && id_rn_rd != 0) begin
                m_busy[id_rn_rd] = 1'b1;
                m_tag[id_rn_rd]  = id_rn_rob_id;
            end
        end
    endtask

    task automatic modelResolve(input logic [4:0] rs, input logic q_rdy, input logic [31:0] q_val,
                                output logic e_rdy, output logic [31:0] e_val,
                                output logic [31:0] e_tag, output logic [31:0] e_qid);
        logic [31:0] t;
        t     = m_tag[rs];
        e_qid = {28'd0, t[3:0]};
        e_rdy = 1'b1;
        e_val = '0;
        e_tag = '0;
        if (rs == 0) begin
            e_val = '0;
        end else if (!m_busy[rs]) begin
            e_val = m_val[rs];
        end else if (cmt_flag && cmt_rd == rs && cmt_rob_id == m_tag[rs]) begin
            e_val = cmt_val;
        end else if (q_rdy) begin
            e_val = q_val;
        end else begin
            e_rdy = 1'b0;
            e_tag = m_tag[rs];
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic [4:0] rn_rd, input logic [31:0] rn_id,
                                 input logic cm, input logic [4:0] c_rd, input logic [31:0] c_id,
                                 input logic [31:0] c_val, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic q1r, input logic [31:0] q1v,
                                 input logic q2r, input logic [31:0] q2v);
        rdy          = 1'b1;
        flush        = 1'b0;
        id_rn_flag   = rn;
        id_rn_rd     = rn_rd;
        id_rn_rob_id = rn_id;
        cmt_flag     = cm;
        cmt_rd       = c_rd;
        cmt_rob_id   = c_id;
        cmt_val      = c_val;
        id_rs1       = r1;
        id_rs2       = r2;
        rob_q1_ready = q1r;
        rob_q1_val   = q1v;
        rob_q2_ready = q2r;
        rob_q2_val   = q2v;
    endtask

    task automatic checkOutput(input string name);
        logic        e_rdy;
        logic [31:0] e_val, e_tag, e_qid;
        #1;
        modelResolve(id_rs1, rob_q1_ready, rob_q1_val, e_rdy, e_val, e_tag, e_qid);
        cmp({name, ".rs1_ready"}, {31'd0, rs1_ready}, {31'd0, e_rdy});
        cmp({name, ".rs1_val"}, rs1_val, e_val);
        cmp({name, ".rs1_tag"}, rs1_tag, e_tag);
        cmp({name, ".rob_q1_id"}, {28'd0, rob_q1_id}, e_qid);
        modelResolve(id_rs2, rob_q2_ready, rob_q2_val, e_rdy, e_val, e_tag, e_qid);
        cmp({name, ".rs2_ready"}, {31'd0, rs2_ready}, {31'd0, e_rdy});
        cmp({name, ".rs2_val"}, rs2_val, e_val);
        cmp({name, ".rs2_tag"}, rs2_tag, e_tag);
        cmp({name, ".rob_q2_id"}, {28'd0, rob_q2_id}, e_qid);
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    initial begin
        modelReset();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        #2;
        checkOutput("in_reset");
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset then read
        checkOutput("after_reset");
        cmp("after_reset.val_const", rs1_val, 32'd0);

        // Rename then stall
        applyStimulus(1, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rename_x3");
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 32'h99, 0, 0);
        checkOutput("stall");
        cmp("stall.ready_const", {31'd0, rs1_ready}, 32'd0);
        cmp("stall.tag_const", rs1_tag, 32'd7);
        cmp("stall.qid_const", {28'd0, rob_q1_id}, 32'd7);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 32'hAB, 0, 0);
        checkOutput("rob_fwd");
        cmp("rob_fwd.val_const", rs1_val, 32'hAB);

        // Commit bypass and clear
        applyStimulus(0, 0, 0, 1, 3, 7, 32'h55, 3, 0, 0, 0, 0, 0);
        checkOutput("bypass");
        cmp("bypass.val_const", rs1_val, 32'h55);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0);
        checkOutput("cleared");
        cmp("cleared.val_const", rs2_val, 32'h55);

        // Stale commit leaves the younger producer pending
        applyStimulus(1, 3, 7, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 3, 9, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 3, 7, 1, 3, 0, 0, 0, 0, 0);
        checkOutput("stale_commit");
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        checkOutput("stale_after");
        cmp("stale_after.tag_const", rs1_tag, 32'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("stale_flushed");
        cmp("stale_flushed.val_const", rs1_val, 32'd1);

        // Same-cycle rename and commit on one register
        applyStimulus(1, 4, 2, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 4, 5, 1, 4, 2, 32'h10, 0, 4, 0, 0, 0, 0);
        checkOutput("rn_cmt_same");
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0);
        checkOutput("rn_cmt_after");
        cmp("rn_cmt_after.tag_const", rs2_tag, 32'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("rn_cmt_value");
        cmp("rn_cmt_value.val_const", rs2_val, 32'h10);

        // Flush with a same-cycle commit and a dropped rename
        applyStimulus(0, 0, 0, 1, 1, 0, 32'hA1, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 2, 0, 32'hA2, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 2, 12, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        tick();
        checkOutput("pre_flush");
        applyStimulus(1, 5, 13, 1, 1, 99, 32'hB1, 1, 2, 0, 0, 0, 0);
        flush = 1'b1;
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        checkOutput("post_flush");
        cmp("post_flush.val1_const", rs1_val, 32'hB1);
        cmp("post_flush.val2_const", rs2_val, 32'hA2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0);
        checkOutput("flush_dropped_rn");

        // x0 ignores rename and commit
        applyStimulus(1, 0, 6, 1, 0, 0, 32'hFF, 0, 0, 0, 0, 1, 32'h77);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        checkOutput("x0");

        // rdy low holds state
        applyStimulus(1, 6, 3, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0);
        rdy = 1'b0;
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0);
        checkOutput("rdy_low");

        // Randomized traffic concentrated on a few registers
        for (int n = 0; n < 400; n++) begin
            logic [4:0]  rrd, crd;
            logic [31:0] rid, cid;
            rrd = 5'($urandom_range(0, 7));
            crd = 5'($urandom_range(0, 7));
            rid = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
            cid = ($urandom_range(0, 3) != 0) ? m_tag[crd] : 32'($urandom_range(0, 40));
            applyStimulus(1'($urandom_range(0, 1)), rrd, rid,
                          1'($urandom_range(0, 1)), crd, cid, $urandom,
                          5'($urandom_range(0, 9) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), $urandom,
                          1'($urandom_range(0, 1)), $urandom);
            flush = ($urandom_range(0, 29) == 0);
            rdy   = ($urandom_range(0, 9) != 0);
            checkOutput("random");
            tick();
        end

        // Asynchronous reset in the middle of operation
        applyStimulus(1, 7, 32'h1234_5678, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        checkOutput("pre_async_rst");
        cmp("pre_async_rst.qid_const", {28'd0, rob_q1_id}, 32'd8);
        #2;
        rst = 1'b0;
        modelReset();
        checkOutput("async_rst");
        cmp("async_rst.ready_const", {31'd0, rs1_ready}, 32'd1);
        cmp("async_rst.qid_const", {28'd0, rob_q1_id}, 32'd0);
        #3;
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with rename tags, directly downstream of the reorder buffer's register-commit port.
- Holds 32 x 32-bit committed values plus a per-register "pending ROB id" tag.
- Decode sets tags on issue. Commit writes values and clears matching tags.
- Resolves two source operands per cycle, forwarding from the ROB when the producing entry is already ready.

Parameters:
- ROB_WD, 4, width of the truncated ROB index sent to the ROB for operand lookup; ROB depth = 2**ROB_WD.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state holds.
- flush  in  1  mispredict pulse; clears all rename tags.
- id_rn_flag  in  1  decode issues an instruction that writes rd.
- id_rn_rd  in  5  destination register of the issued instruction.
- id_rn_rob_id  in  32  full ROB id assigned to that instruction.
- id_rs1  in  5  source register 1.
- id_rs2  in  5  source register 2.
- rs1_ready  out  1  operand 1 value is valid.
- rs1_val  out  32  operand 1 value; 0 when not ready.
- rs1_tag  out  32  producing ROB id; 0 when ready.
- rs2_ready / rs2_val / rs2_tag  out  1/32/32  same as the rs1 outputs, for operand 2.
- rob_q1_id  out  ROB_WD  truncated tag of rs1, sent to the ROB.
- rob_q2_id  out  ROB_WD  truncated tag of rs2, sent to the ROB.
- rob_q1_ready  in  1  ROB entry for rob_q1_id is ready.
- rob_q1_val  in  32  value of that ROB entry.
- rob_q2_ready / rob_q2_val  in  1/32  same, for rob_q2_id.
- cmt_flag  in  1  ROB commits a register write.
- cmt_rd  in  5  committed destination register.
- cmt_rob_id  in  32  ROB id of the committing entry.
- cmt_val  in  32  committed value.

Behaviour:
- Reset (rst=0, async):
  - all 32 values = 0, all busy = 0, all tags = 0.
  - No outputs are registered. After reset, every rsN_ready = 1, rsN_val = 0, rsN_tag = 0.
- Sequential update on posedge clk, only when rst=1 and rdy=1.
- flush=1 has priority over everything else in the cycle:
  - all busy bits cleared.
  - a commit in the same cycle still writes its value.
  - the rename in the same cycle is dropped.
- Commit, when cmt_flag=1 and cmt_rd != 0:
  - value[cmt_rd] <= cmt_val.
  - busy[cmt_rd] cleared only if busy[cmt_rd] is set and tag[cmt_rd] == cmt_rob_id; otherwise the tag is untouched, because a younger producer is still pending.
- Rename, when id_rn_flag=1 and id_rn_rd != 0:
  - busy[id_rn_rd] <= 1, tag[id_rn_rd] <= id_rn_rob_id.
  - On the same register in the same cycle as a commit, rename wins the busy/tag update; the value is still written.
- x0: never busy, value always 0; writes and renames to x0 are ignored.
- Operand resolution is combinational, same cycle, in this priority order:
  1. rs == 0 -> ready, value 0.
  2. not busy -> ready, value[rs].
  3. busy, and cmt_flag with cmt_rd == rs and cmt_rob_id == tag -> ready, cmt_val (commit bypass).
  4. busy and rob_qN_ready -> ready, rob_qN_val.
  5. Otherwise not ready; tag = tag[rs], val = 0.
- rob_qN_id = tag[rs][ROB_WD-1:0] regardless of busy state.
- Operands read the pre-update state: a rename issued this cycle does not affect this cycle's reads. Decode must not rename before reading its own sources within the same instruction.
- rdy=0: no state change; combinational outputs stay live.

Decomposition:
- Shared definitions file (existing global defines): True/False constants, ROB_WD, register count 32, x0 index.
- One sub-module: operand_resolve, instantiated twice, one per source. It is purely combinational and implements resolution priorities 1-5. The storage and update logic stays in register_file.

Test Plan:
- Reset then read: rst low then high; read rs1=5, rs2=0 -> both ready, val 0, tag 0.
- Rename then stall:
  - Cycle 1: rename rd=3, rob_id=7.
  - Cycle 2: read rs1=3 with rob_q1_ready=0 -> ready=0, tag=7, rob_q1_id=7.
  - With rob_q1_ready=1 and rob_q1_val=0xAB -> ready=1, val=0xAB.
- Commit bypass and clear:
  - Same cycle as reading rs1=3: commit rd=3, rob_id=7, val=0x55 -> rs1 ready, val 0x55.
  - Next cycle -> not busy, val 0x55.
- Stale commit:
  - rename x3 to 7, then rename x3 to 9.
  - commit rd=3, rob_id=7, val=1 -> value[3]=1, busy stays set, tag stays 9.
- Same-cycle rename and commit:
  - x4 tag 2; cycle N: commit rd=4 id=2 val=0x10 and rename rd=4 id=5.
  - Next cycle -> busy, tag 5, value 0x10.
- Flush, x0, and reset:
  - x1 and x2 busy; pulse flush -> both ready next cycle with committed values.
  - Rename and commit to x0 -> no change.
  - Assert rst mid-operation -> all state clears immediately, without a clock edge.
